// File: rtl/cpu_prefetch_pkg.sv
// Shared definitions for the cpu_prefetch instruction fetch unit: opcode
// constants for branch-class detection, FSM state encoding and the queue
// entry layout.
package cpu_prefetch_pkg;

    // Control-transfer opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_FETCH       = 2'd1;
    localparam logic [1:0] ST_DISCARD     = 2'd2;
    localparam logic [1:0] ST_WAIT_BRANCH = 2'd3;

    // Widest sequence tag an entry can carry; narrower tags are zero-extended
    localparam int unsigned PF_TAG_MAX = 32;

    typedef struct packed {
        logic [PF_TAG_MAX-1:0] tag;
        logic [31:0]           instruction;
        logic [31:0]           pc;
    } pf_entry_t;

    // True for conditional branches, JAL and JALR
    function automatic logic is_branch_class(input logic [31:0] insn);
        logic w_hit;
        case (insn[6:0])
            OP_BRANCH, OP_JAL, OP_JALR: w_hit = 1'b1;
            default:                    w_hit = 1'b0;
        endcase
        return w_hit;
    endfunction

    // Fetch addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO holding prefetched instructions. The head
// entry and its valid flag are registered from the next-state head so a
// push into an empty queue is visible right after the pushing edge.
module cpu_prefetch_fifo
    import cpu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  pf_entry_t              i_push_data,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_head_valid,
    output pf_entry_t              o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    pf_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_head_valid;
    pf_entry_t        r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;
    pf_entry_t        w_head_next;

    // Qualify requests against occupancy and compute next pointers, count and head
    always_comb begin
        w_pop        = i_pop && (r_count != '0) && !i_clear;
        w_push       = i_push && !i_clear && ((r_count != FULL_COUNT) || w_pop);
        w_rd_next    = r_rd_ptr;
        w_count_next = r_count;
        w_head_next  = '0;
        if (w_pop) begin
            w_rd_next = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_next = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
        if (w_count_next == '0) begin
            w_head_next = '0;
        end else if (w_push && (w_rd_next == r_wr_ptr)) begin
            // Queue drains to exactly the entry being written this cycle
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array; data only, no reset needed
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered head with reset and clear
    always_ff @(posedge i_clock) begin
        if (!i_reset || i_clear) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head       <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_count_next;
            r_head_valid <= (w_count_next != '0);
            r_head       <= w_head_next;
        end
    end

    assign o_count      = r_count;
    assign o_full       = (r_count == FULL_COUNT);
    assign o_empty      = (r_count == '0);
    assign o_head_valid = r_head_valid;
    assign o_head       = r_head;

endmodule

// File: rtl/cpu_prefetch.sv
// Instruction fetch unit with prefetch queue. Issues sequential word fetches
// (one outstanding), buffers tagged instructions for decode and flushes on
// redirect. Optional feature macro: CPU_PREFETCH_SPECULATE_EN -- when defined,
// fetch runs past branch-class instructions; otherwise fetch stalls in
// WAIT_BRANCH until the redirect arrives. TAG_WIDTH must not exceed PF_TAG_MAX.
module cpu_prefetch
    import cpu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 8,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    output logic                 o_bus_request,
    input  logic                 i_bus_ready,
    output logic [31:0]          o_bus_address,
    input  logic [31:0]          i_bus_rdata,
    input  logic                 i_branch,
    input  logic [31:0]          i_pc_next,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_instruction,
    output logic [31:0]          o_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    logic [1:0]           r_state;
    logic [31:0]          r_pc;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_bus_request;
    logic [31:0]          r_bus_address;

    logic [1:0]           w_state_next;
    logic [31:0]          w_pc_next;
    logic [TAG_WIDTH-1:0] w_tag_next;
    logic                 w_req_next;
    logic [31:0]          w_addr_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_space_b2b;
    logic                 w_hold_on_branch;
    logic [31:0]          w_target;
    logic [31:0]          w_pc_seq;
    logic [TAG_WIDTH-1:0] w_tag_inc;
    pf_entry_t            w_push_entry;
    pf_entry_t            w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_head_valid;
    logic                 w_unused_tag;

    assign w_target  = word_align(i_pc_next);
    assign w_pc_seq  = r_pc + 32'd4;
    assign w_tag_inc = r_tag + TAG_WIDTH'(1'b1);

    // head_valid mirrors !empty; both must agree before decode may pop
    assign w_pop = w_head_valid && i_ready && !w_fifo_empty;

    // After this push (and any same-cycle pop) one more slot must remain free
    assign w_space_b2b = (w_count < CNT_LAST) || w_pop;

`ifdef CPU_PREFETCH_SPECULATE_EN
    assign w_hold_on_branch = 1'b0;
`else
    assign w_hold_on_branch = is_branch_class(i_bus_rdata);
`endif

    // Assemble the entry written on a completed fetch
    always_comb begin
        w_push_entry                        = '0;
        w_push_entry.tag[TAG_WIDTH-1:0]     = w_tag_inc;
        w_push_entry.instruction            = i_bus_rdata;
        w_push_entry.pc                     = r_pc;
    end

    // Fetch FSM next-state and bus request generation
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_tag_next   = r_tag;
        w_req_next   = r_bus_request;
        w_addr_next  = r_bus_address;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_branch) begin
                    // Queue is being cleared, so the target can go out at once
                    w_pc_next    = w_target;
                    w_req_next   = 1'b1;
                    w_addr_next  = w_target;
                    w_state_next = ST_FETCH;
                end else if (!w_fifo_full) begin
                    w_req_next   = 1'b1;
                    w_addr_next  = r_pc;
                    w_state_next = ST_FETCH;
                end else begin
                    w_req_next   = 1'b0;
                end
            end
            ST_FETCH: begin
                if (i_bus_ready && i_branch) begin
                    // Returning data belongs to the old path
                    w_pc_next    = w_target;
                    w_req_next   = 1'b0;
                    w_state_next = ST_IDLE;
                end else if (i_bus_ready) begin
                    w_push     = 1'b1;
                    w_tag_next = w_tag_inc;
                    w_pc_next  = w_pc_seq;
                    if (w_hold_on_branch) begin
                        w_req_next   = 1'b0;
                        w_state_next = ST_WAIT_BRANCH;
                    end else if (w_space_b2b) begin
                        w_req_next   = 1'b1;
                        w_addr_next  = w_pc_seq;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_req_next   = 1'b0;
                        w_state_next = ST_IDLE;
                    end
                end else if (i_branch) begin
                    // Request must stay up until the slave answers
                    w_pc_next    = w_target;
                    w_state_next = ST_DISCARD;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (i_branch) begin
                    w_pc_next = w_target;
                end else begin
                    w_pc_next = r_pc;
                end
                if (i_bus_ready) begin
                    w_req_next   = 1'b0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_WAIT_BRANCH: begin
                if (i_branch) begin
                    w_pc_next    = w_target;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_BRANCH;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Fetch state, pc, tag and bus request registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= word_align(RESET_PC);
            r_tag         <= '0;
            r_bus_request <= 1'b0;
            r_bus_address <= word_align(RESET_PC);
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_tag         <= w_tag_next;
            r_bus_request <= w_req_next;
            r_bus_address <= w_addr_next;
        end
    end

    cpu_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (i_branch),
        .o_count      (w_count),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_valid (w_head_valid),
        .o_head       (w_head)
    );

    // Upper tag bits are always zero; fold them so they count as consumed
    assign w_unused_tag = ^w_head.tag;

    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_valid       = w_head_valid;
    assign o_tag         = w_head.tag[TAG_WIDTH-1:0];
    assign o_instruction = w_head.instruction;
    assign o_pc          = w_head.pc;

endmodule

// File: tb/tb_cpu_prefetch.sv
// Directed self-checking bench for cpu_prefetch (DEPTH=4, TAG_WIDTH=8).
// A small bus slave answers each request after a programmable latency;
// expected values are hand-derived from the fetch sequence.
module tb_cpu_prefetch;

    logic        clk;
    logic        i_reset;
    logic        o_bus_request;
    logic        i_bus_ready;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;
    logic        i_branch;
    logic [31:0] i_pc_next;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_tag;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          latency  = 1;
    int          slave_cnt;
    logic [31:0] beq_addr = 32'hFFFF_FFF0;
    logic [31:0] ans_q [$];

    cpu_prefetch #(
        .DEPTH     (4),
        .TAG_WIDTH (8),
        .RESET_PC  (32'h0)
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .i_branch      (i_branch),
        .i_pc_next     (i_pc_next),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_tag         (o_tag),
        .o_instruction (o_instruction),
        .o_pc          (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: ADDI-class words, one optional BEQ
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == beq_addr) return 32'h0000_0063;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Bus slave: answers a held request after 'latency' cycles, logs answered addresses
    initial begin
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'h0;
        slave_cnt   = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!i_reset) begin
                i_bus_ready = 1'b0;
                slave_cnt   = 0;
                ans_q.delete();
            end else begin
                if (i_bus_ready) begin
                    i_bus_ready = 1'b0;
                    slave_cnt   = 0;
                end
                if (o_bus_request) begin
                    slave_cnt++;
                    if (slave_cnt >= latency) begin
                        i_bus_ready = 1'b1;
                        i_bus_rdata = mem_word(o_bus_address);
                        ans_q.push_back(o_bus_address);
                    end
                end else begin
                    slave_cnt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        i_reset   = 1'b0;
        i_branch  = 1'b0;
        i_pc_next = 32'h0;
        i_ready   = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
    endtask

    // Wait (bounded) for a valid head, check it, then step past its pop edge
    task automatic expect_head(input logic [7:0] tag, input logic [31:0] pc);
        for (int n = 0; n < 40 && !o_valid; n++) @(negedge clk);
        check_eq("head_valid", {31'd0, o_valid}, 32'd1);
        check_eq("head_tag", {24'd0, o_tag}, {24'd0, tag});
        check_eq("head_pc", o_pc, pc);
        check_eq("head_insn", o_instruction, mem_word(pc));
        @(negedge clk);
    endtask

    task automatic skip_head();
        for (int n = 0; n < 40 && !o_valid; n++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [31:0] addr);
        for (int n = 0; n < 40 && !(o_bus_request && o_bus_address == addr); n++) @(negedge clk);
    endtask

    initial begin
        i_reset   = 1'b0;
        i_branch  = 1'b0;
        i_pc_next = 32'h0;
        i_ready   = 1'b0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check_eq("rst_req",  {31'd0, o_bus_request}, 32'd0);
        check_eq("rst_addr", o_bus_address, 32'h0);
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_tag",  {24'd0, o_tag}, 32'd0);
        check_eq("rst_insn", o_instruction, 32'h0);
        check_eq("rst_pc",   o_pc, 32'h0);

        // ---- sequential fetch, 1-cycle bus, decode always ready ----
        latency = 1;
        i_ready = 1'b1;
        i_reset = 1'b1;
        @(negedge clk);
        check_eq("first_req",  {31'd0, o_bus_request}, 32'd1);
        check_eq("first_addr", o_bus_address, 32'h0);
        expect_head(8'd1, 32'h0);
        expect_head(8'd2, 32'h4);
        expect_head(8'd3, 32'h8);
        check_eq("b2b_addr", ans_q[3], 32'hC);

        // ---- queue fills with decode stalled ----
        do_reset();
        latency = 1;
        repeat (12) @(negedge clk);
        check_eq("full_req",   {31'd0, o_bus_request}, 32'd0);
        check_eq("full_count", ans_q.size(), 32'd4);
        check_eq("full_valid", {31'd0, o_valid}, 32'd1);
        check_eq("full_tag",   {24'd0, o_tag}, 32'd1);
        i_ready = 1'b1;
        expect_head(8'd1, 32'h0);
        expect_head(8'd2, 32'h4);
        expect_head(8'd3, 32'h8);
        expect_head(8'd4, 32'hC);
        expect_head(8'd5, 32'h10);
        check_eq("resume_addr", ans_q[4], 32'h10);

        // ---- redirect while a slow request to 0x8 is outstanding ----
        do_reset();
        latency = 3;
        wait_req(32'h8);
        check_eq("disc_req8", o_bus_address, 32'h8);
        i_branch  = 1'b1;
        i_pc_next = 32'h200;
        @(negedge clk);
        i_branch = 1'b0;
        check_eq("disc_hold_req",  {31'd0, o_bus_request}, 32'd1);
        check_eq("disc_hold_addr", o_bus_address, 32'h8);
        check_eq("disc_flush",     {31'd0, o_valid}, 32'd0);
        for (int n = 0; n < 40 && !o_valid; n++) @(negedge clk);
        check_eq("disc_next_addr", ans_q[3], 32'h200);
        check_eq("disc_head_pc",   o_pc, 32'h200);
        check_eq("disc_head_tag",  {24'd0, o_tag}, 32'd3);

        // ---- redirect coinciding with bus ready ----
        do_reset();
        latency = 1;
        i_ready = 1'b1;
        wait_req(32'h8);
        check_eq("brr_req8", o_bus_address, 32'h8);
        i_branch  = 1'b1;
        i_pc_next = 32'h300;
        @(negedge clk);
        i_branch = 1'b0;
        check_eq("brr_req_drop", {31'd0, o_bus_request}, 32'd0);
        check_eq("brr_flush",    {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        check_eq("brr_req",  {31'd0, o_bus_request}, 32'd1);
        check_eq("brr_addr", o_bus_address, 32'h300);
        expect_head(8'd3, 32'h300);

        // ---- tag wrap 255 -> 0 ----
        do_reset();
        latency = 1;
        i_ready = 1'b1;
        for (int i = 1; i < 255; i++) skip_head();
        expect_head(8'd255, 32'h3F8);
        expect_head(8'd0,   32'h3FC);

        // ---- branch-class instruction at 0x4 ----
        beq_addr = 32'h4;
        do_reset();
        latency = 1;
        i_ready = 1'b1;
        expect_head(8'd1, 32'h0);
        expect_head(8'd2, 32'h4);
        repeat (6) @(negedge clk);
`ifdef CPU_PREFETCH_SPECULATE_EN
        check_eq("spec_third_addr", ans_q[2], 32'h8);
        check_eq("spec_req", {31'd0, o_bus_request}, 32'd1);
`else
        check_eq("wait_req",   {31'd0, o_bus_request}, 32'd0);
        check_eq("wait_count", ans_q.size(), 32'd2);
        i_branch  = 1'b1;
        i_pc_next = 32'h40;
        @(negedge clk);
        i_branch = 1'b0;
        expect_head(8'd3, 32'h40);
        check_eq("wait_redirect_addr", ans_q[2], 32'h40);
`endif
        beq_addr = 32'hFFFF_FFF0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time in case the stimulus itself stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
